// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM state encoding,
// the key-code map and the row-priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Indexed by col*4+row. Physical layout, row0..row3 across col0..col3:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [15:0][3:0] KEYMAP = 64'hDCBA_F963_0852_E741;

  // Index of the lowest-numbered row that reads low (closed key).
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Scan tick divider: counts 0..CLK_FREQ/SCAN_HZ-1 and asserts tick for the
// single cycle at the terminal count.
module scan_tick_gen #(
  parameter int CLK_FREQ = 16_000_000,
  parameter int SCAN_HZ  = 500
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int DIV = CLK_FREQ / SCAN_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] count;

  // Free-running divider, wraps at the terminal count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             count <= '0;
    else if (count == TERM) count <= '0;
    else                    count <= count + W'(1);
  end

  assign tick = (count == TERM);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with debounced press/release detection.
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, key_valid
// re-pulses every SCAN_HZ/4 ticks. Undefined: one key_valid per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ       = 16_000_000,
  parameter int SCAN_HZ        = 500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  row_pins,
  output logic [3:0]  column_pins,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] key_onehot
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic        tick;
  logic [3:0]  rows_meta, rows_sync;
  state_t      state, state_next;
  logic [1:0]  col, col_next;
  logic [1:0]  lrow, lrow_next;
  logic [3:0]  cnt, cnt_next, cnt_inc;
  logic [3:0]  key_idx;
  logic        row_low;
  logic [3:0]  code_next;
  logic        valid_next, held_next;
  logic [15:0] onehot_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_TICKS = SCAN_HZ / 4;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [RW-1:0] REP_N = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep, rep_next, rep_inc;
  assign rep_inc = rep + RW'(1);
`endif

  scan_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_HZ  (SCAN_HZ)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= row_pins;
      rows_sync <= rows_meta;
    end
  end

  assign column_pins = ~(4'b0001 << col);
  assign cnt_inc     = cnt + 4'd1;
  assign key_idx     = {col, lrow};
  assign row_low     = !rows_sync[lrow];

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= SCAN;
    else        state <= state_next;
  end

  // Next-state and output decisions; the matrix is only evaluated on ticks.
  always_comb begin
    state_next  = state;
    col_next    = col;
    lrow_next   = lrow;
    cnt_next    = cnt;
    code_next   = key_code;
    valid_next  = 1'b0;
    held_next   = key_held;
    onehot_next = key_onehot;
`ifdef KEYPAD_REPEAT_EN
    rep_next    = rep;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (rows_sync != 4'hF) begin
            lrow_next  = low_row(rows_sync);
            cnt_next   = 4'd1;
            state_next = DEBOUNCE;
          end else begin
            col_next = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_low) begin
            if (cnt_inc >= DB_N) begin
              code_next   = KEYMAP[key_idx];
              valid_next  = 1'b1;
              held_next   = 1'b1;
              onehot_next = 16'h0001 << key_idx;
              cnt_next    = 4'd0;
              state_next  = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_next    = '0;
`endif
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            // Bounce before confirmation: drop it silently and keep scanning.
            cnt_next   = 4'd0;
            col_next   = col + 2'd1;
            state_next = SCAN;
          end
        end
        HELD: begin
          if (!row_low) begin
            if (cnt_inc >= DB_N) begin
              held_next   = 1'b0;
              onehot_next = 16'h0000;
              cnt_next    = 4'd0;
              col_next    = col + 2'd1;
              state_next  = SCAN;
            end else begin
              cnt_next = cnt_inc;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_next = '0;
`endif
          end else begin
            // Still closed: any partial release count is discarded.
            cnt_next = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == REP_N) begin
              valid_next = 1'b1;
              rep_next   = '0;
            end else begin
              rep_next = rep_inc;
            end
`endif
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col        <= 2'd0;
      lrow       <= 2'd0;
      cnt        <= 4'd0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      key_onehot <= 16'h0000;
    end else begin
      col        <= col_next;
      lrow       <= lrow_next;
      cnt        <= cnt_next;
      key_code   <= code_next;
      key_valid  <= valid_next;
      key_held   <= held_next;
      key_onehot <= onehot_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat interval counter, only present in the auto-repeat build.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rep <= '0;
    else        rep <= rep_next;
  end
`endif

endmodule
